nios2_mult_cell_iter: RTL
=========================

Name: nios2_mult_cell_iter

Overview:
Parametrised iterative integer multiplier for the Nios II custom/ALU datapath. Successor to the fixed 32x32 two-partial-product multiplier cell.
- Splits DATA_W operands into PIECE_W slices and uses one PIECE_W x PIECE_W multiplier, one partial product per cycle.
- Supports low-word and signed/unsigned high-word modes, which the fixed cell does not.
- Uses a valid/ready handshake on both sides and a synchronous flush.

Parameters:
DATA_W, 32, operand and result width; must be a multiple of PIECE_W.
PIECE_W, 16, slice width of the single hardware multiplier.
N (localparam), DATA_W/PIECE_W, slices per operand; N >= 1.

Ports:
clk  in  1  clock; all state changes on the rising edge.
reset  in  1  asynchronous, active-high reset.
flush  in  1  synchronous abort; returns to IDLE, drops any operation.
in_valid  in  1  operands and mode presented.
in_ready  out  1  block can accept; high only in IDLE.
in_src1  in  DATA_W  operand A.
in_src2  in  DATA_W  operand B.
in_mode  in  2  operation select:
- 0 = MUL, low DATA_W bits.
- 1 = MULXUU, high word, unsigned x unsigned.
- 2 = MULXSU, high word, signed A x unsigned B.
- 3 = MULXSS, high word, signed x signed.
out_valid  out  1  result valid; held until out_ready.
out_ready  in  1  consumer accepts result.
out_result  out  DATA_W  selected product word.

Behaviour:
Interface:
- One clock, clk.
- Reset is asynchronous and active-high, port name reset.

Reset values:
- State = IDLE.
- in_ready = 1, out_valid = 0, out_result = 0.
- Accumulator, counters and operand registers = 0.

States:
- IDLE: in_ready = 1. When in_valid=1, on the edge:
  - latch src1, src2 and mode;
  - clear the 2*DATA_W accumulator and slice indices i=0, j=0;
  - go to MUL.
- MUL: each cycle, acc += (A[i] * B[j]) << ((i+j)*PIECE_W).
  - The sum is truncated to 2*DATA_W bits; slices are taken unsigned.
  - Pair order: i outer, j inner, both 0..N-1.
  - In mode MUL, pairs with i+j >= N are skipped without costing a cycle.
  - The state advances to FIX after the last needed pair.
  - Partial-product count P = N*(N+1)/2 for MUL and N*N for high modes. With N=2: P=3 and P=4.
- FIX: exactly one cycle in every mode. hi = acc[2*DATA_W-1:DATA_W], corrected as follows:
  - MULXSU: hi -= (A<0 ? B : 0).
  - MULXSS: hi -= (A<0 ? B : 0) + (B<0 ? A : 0).
  - MULXUU: no correction.
  - All arithmetic is mod 2^DATA_W.
  - Register out_result = hi for high modes, acc[DATA_W-1:0] for MUL. Go to DONE.
- DONE: out_valid = 1, out_result stable. When out_ready=1: out_valid -> 0 and state -> IDLE on that edge.
  - No back-to-back overlap: the next accept is no earlier than the cycle after the handshake.

Latency:
- Accept edge at cycle 0.
- out_valid is first high in cycle P+2.
- Throughput is one operation per P+3 cycles when out_ready is held high.

Boundaries:
- in_valid is ignored outside IDLE.
- out_result holds its last value after the handshake until the next FIX.
- flush has priority over all transitions, including a DONE handshake in the same cycle. It drives out_valid=0 and in_ready=1 next cycle.
- reset mid-operation behaves identically, asynchronously.
- N=1: P=1 for all modes.
- Mode is sampled only at accept; later in_mode changes have no effect.

Decomposition:
Shared package nios2_mult_pkg holds:
- mode encodings MODE_MUL/MODE_MULXUU/MODE_MULXSU/MODE_MULXSS;
- the state enum IDLE/MUL/FIX/DONE;
- a function returning P for a given mode and N.

One sub-module, nios2_mult_slice: a registered-free PIECE_W x PIECE_W unsigned multiplier. It maps to the dedicated DSP block so that other cells can swap in vendor primitives. Everything else stays in the top.

Test Plan:
- MUL, N=2, A=32'h0001_0003, B=32'h0002_0005 -> out_result=32'h000B_000F; out_valid first high 5 cycles after accept.
- MULXUU, same operands -> 32'h0000_0002, out_valid at cycle 6. MULXUU, A=B=32'hFFFF_FFFF -> 32'hFFFF_FFFE.
- MULXSS, A=B=32'hFFFF_FFFF -> 32'h0000_0000. MULXSU, A=B=32'hFFFF_FFFF -> 32'hFFFF_FFFF. MULXSS, A=32'h8000_0000, B=32'h0000_0002 -> 32'hFFFF_FFFF.
- Backpressure: hold out_ready=0 for 10 cycles in DONE.
  - Required: out_valid and out_result stable, in_ready=0, new in_valid ignored.
  - On release, exactly one transfer; in_ready=1 the following cycle.
- Assert flush, and separately reset, during MUL cycle 2.
  - Required: out_valid never rises; in_ready=1 next cycle (immediately for reset).
  - A following MUL 7*6 returns 42 with normal latency.
- Random regression against a 64-bit reference model: all modes, DATA_W=32/PIECE_W=16, DATA_W=32/PIECE_W=8 (N=4, P=10/16), and DATA_W=16/PIECE_W=16. Random out_ready stalls.

Source files
------------

// File: rtl/nios2_mult_pkg.sv
// Shared encodings and helpers for the iterative Nios II multiplier cell.
package nios2_mult_pkg;

  localparam logic [1:0] MODE_MUL    = 2'd0;
  localparam logic [1:0] MODE_MULXUU = 2'd1;
  localparam logic [1:0] MODE_MULXSU = 2'd2;
  localparam logic [1:0] MODE_MULXSS = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } mult_state_e;

  // Partial products needed: the low word only needs pairs with i+j < n.
  function automatic int unsigned num_products(input logic [1:0] mode, input int unsigned n);
    return (mode == MODE_MUL) ? (n * (n + 1)) / 2 : n * n;
  endfunction

endpackage

// File: rtl/nios2_mult_slice.sv
// Unregistered PIECE_W x PIECE_W unsigned multiplier; kept separate so a vendor
// DSP primitive can be dropped in without touching the sequencer.
module nios2_mult_slice
  import nios2_mult_pkg::*;
#(
  parameter int PIECE_W = 16
) (
  input  logic [PIECE_W-1:0]   a,
  input  logic [PIECE_W-1:0]   b,
  output logic [2*PIECE_W-1:0] p
);

  assign p = (2*PIECE_W)'(a) * (2*PIECE_W)'(b);

endmodule

// File: rtl/nios2_mult_cell_iter.sv
// Iterative multiplier: one PIECE_W x PIECE_W partial product per cycle into a
// 2*DATA_W accumulator, then a one-cycle signed high-word correction.
//
// state | meaning
// IDLE  | in_ready high, operands latched on in_valid
// MUL   | accumulate one slice pair per cycle
// FIX   | apply sign correction, register selected word
// DONE  | out_valid high until out_ready
module nios2_mult_cell_iter
  import nios2_mult_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int PIECE_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_src1,
  input  logic [DATA_W-1:0] in_src2,
  input  logic [1:0]        in_mode,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result
);

  localparam int N     = DATA_W / PIECE_W;
  localparam int ACC_W = 2 * DATA_W;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);

  mult_state_e          state_q, state_d;
  logic [DATA_W-1:0]    a_q, b_q;
  logic [1:0]           mode_q;
  logic [ACC_W-1:0]     acc_q;
  logic [IDX_W-1:0]     i_q, j_q, j_last;
  logic                 last_pair;
  logic [PIECE_W-1:0]   a_slice, b_slice;
  logic [2*PIECE_W-1:0] prod;
  logic [ACC_W-1:0]     prod_shifted;
  logic [DATA_W-1:0]    corr, fix_result;

  assign a_slice = PIECE_W'(a_q >> (32'(i_q) * PIECE_W));
  assign b_slice = PIECE_W'(b_q >> (32'(j_q) * PIECE_W));

  nios2_mult_slice #(.PIECE_W(PIECE_W)) u_slice (
    .a (a_slice),
    .b (b_slice),
    .p (prod)
  );

  assign prod_shifted = ACC_W'(prod) << ((32'(i_q) + 32'(j_q)) * PIECE_W);

  // Low-word mode stops the inner loop at i+j = N-1; higher pairs cannot reach it.
  assign j_last    = (mode_q == MODE_MUL) ? LAST - i_q : LAST;
  assign last_pair = (i_q == LAST) && (j_q == j_last);

  // Unsigned product high word minus the two's-complement terms of negative operands.
  always_comb begin
    corr = '0;
    if ((mode_q == MODE_MULXSU || mode_q == MODE_MULXSS) && a_q[DATA_W-1]) corr = b_q;
    if (mode_q == MODE_MULXSS && b_q[DATA_W-1]) corr = corr + a_q;
    fix_result = (mode_q == MODE_MUL) ? acc_q[DATA_W-1:0] : acc_q[ACC_W-1:DATA_W] - corr;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (in_valid) state_d = MUL;
      MUL:     if (last_pair) state_d = FIX;
      FIX:     state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      a_q        <= '0;
      b_q        <= '0;
      mode_q     <= MODE_MUL;
      acc_q      <= '0;
      i_q        <= '0;
      j_q        <= '0;
      out_result <= '0;
    end else begin
      state_q <= state_d;
      if (!flush) begin
        unique case (state_q)
          IDLE: if (in_valid) begin
            a_q    <= in_src1;
            b_q    <= in_src2;
            mode_q <= in_mode;
            acc_q  <= '0;
            i_q    <= '0;
            j_q    <= '0;
          end
          MUL: begin
            acc_q <= acc_q + prod_shifted;
            if (j_q == j_last) begin
              j_q <= '0;
              i_q <= i_q + IDX_W'(1);
            end else begin
              j_q <= j_q + IDX_W'(1);
            end
          end
          FIX:     out_result <= fix_result;
          default: ;
        endcase
      end
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);

endmodule
